// File: rtl/sq_pkg.sv
// Shared types and defaults for the Sq (mod 2^LOGQ) arithmetic blocks.
package sq_pkg;

    localparam int unsigned LOGQ_DEFAULT = 13;
    localparam int unsigned HRSS_N       = 701;

    typedef logic [LOGQ_DEFAULT-1:0] coeff_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } mac_state_e;

endpackage

// File: rtl/sq_mac_lane.sv
// One MAC lane: stage-1 product register, stage-2 accumulator mod 2^LOGQ.
module sq_mac_lane
    import sq_pkg::*;
#(
    parameter int unsigned LOGQ = LOGQ_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            load,
    input  logic            apply,
    input  logic [LOGQ-1:0] a,
    input  logic [LOGQ-1:0] b,
    input  logic            sub,
    output logic [LOGQ-1:0] acc
);

    logic [LOGQ-1:0] prod;
    logic            s1_sub;

    // The LOGQ-bit assignment context keeps only the low bits of a*b.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prod   <= '0;
            s1_sub <= 1'b0;
            acc    <= '0;
        end else begin
            if (load) begin
                prod   <= a * b;
                s1_sub <= sub;
            end
            if (clr) begin
                acc <= '0;
            end else if (apply) begin
                acc <= s1_sub ? acc - prod : acc + prod;
            end
        end
    end

endmodule

// File: rtl/sq_mac_array.sv
// Multi-lane multiply-accumulate engine over Z_(2^LOGQ): start/len job control,
// broadcast operand handshake, two-stage lane pipeline and result handshake.
module sq_mac_array
    import sq_pkg::*;
#(
    parameter  int unsigned LOGQ    = LOGQ_DEFAULT,
    parameter  int unsigned LANES   = 4,
    parameter  int unsigned MAX_LEN = HRSS_N,
    localparam int unsigned CW      = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CW-1:0]         cfg_len,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LOGQ-1:0]       in_a,
    input  logic [LANES*LOGQ-1:0] in_b,
    input  logic                  in_sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*LOGQ-1:0] out_acc
);

    mac_state_e    state_q, state_d;
    logic [CW-1:0] len_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] len_clamped;
    logic          s1_valid;
    logic          start_ok;
    logic          accept;
    logic          last_beat;

    assign len_clamped = (cfg_len > CW'(MAX_LEN)) ? CW'(MAX_LEN) : cfg_len;
    assign start_ok    = (state_q == IDLE) && start;
    assign accept      = (state_q == ACCUM) && in_valid;
    assign last_beat   = accept && ((cnt_q + CW'(1)) == len_q);

    assign busy      = (state_q != IDLE);
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = (len_clamped == '0) ? DONE : ACCUM;
            ACCUM: if (last_beat) state_d = DRAIN;
            DRAIN: if (!s1_valid) state_d = DONE;
            DONE:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            s1_valid <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_valid <= accept;
            if (start_ok) begin
                len_q <= len_clamped;
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sq_mac_lane #(
            .LOGQ(LOGQ)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .clr  (start_ok),
            .load (accept),
            .apply(s1_valid),
            .a    (in_a),
            .b    (in_b[l*LOGQ +: LOGQ]),
            .sub  (in_sub),
            .acc  (out_acc[l*LOGQ +: LOGQ])
        );
    end

endmodule

// File: tb/tb_sq_mac_array.sv
// Directed bench for sq_mac_array: beat-level modular model plus literal results.
module tb_sq_mac_array;

    localparam int LOGQ    = 13;
    localparam int LANES   = 4;
    localparam int MAX_LEN = 701;
    localparam int CW      = $clog2(MAX_LEN + 1);
    localparam int W       = LOGQ * LANES;
    localparam int Q       = 1 << LOGQ;

    logic          clk;
    logic          rst;
    logic          start;
    logic [CW-1:0] cfg_len;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [LOGQ-1:0] in_a;
    logic [W-1:0]  in_b;
    logic          in_sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_acc;

    sq_mac_array #(
        .LOGQ   (LOGQ),
        .LANES  (LANES),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_len  (cfg_len),
        .busy     (busy),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_sub   (in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_acc  (out_acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int unsigned mdl_acc[LANES];
    logic [W-1:0] held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mdl_pack();
        logic [W-1:0] r;
        r = '0;
        for (int l = 0; l < LANES; l++) r[l*LOGQ +: LOGQ] = LOGQ'(mdl_acc[l]);
        return r;
    endfunction

    // Lane l holds s*(l+1) mod q.
    function automatic logic [W-1:0] lanes_lin(input int s);
        logic [W-1:0] r;
        r = '0;
        for (int l = 0; l < LANES; l++) r[l*LOGQ +: LOGQ] = LOGQ'((s * (l + 1)) % Q);
        return r;
    endfunction

    function automatic logic [W-1:0] lanes_all(input int v);
        logic [W-1:0] r;
        r = '0;
        for (int l = 0; l < LANES; l++) r[l*LOGQ +: LOGQ] = LOGQ'(v % Q);
        return r;
    endfunction

    // Whenever results are presented they must equal the model's sums.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (out_valid === 1'b1) check("out_acc_vs_model", 64'(out_acc), 64'(mdl_pack()));
            if (busy === 1'b0) check("idle_quiet", {62'd0, in_ready, out_valid}, 64'd0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_job(input int len);
        check("start_in_idle", 64'(busy), 64'd0);
        start   = 1'b1;
        cfg_len = CW'(len);
        for (int l = 0; l < LANES; l++) mdl_acc[l] = 0;
        tick();
        start = 1'b0;
    endtask

    // Lane l operand b = (bmul*(l+1) + badd) mod q.
    task automatic beat(input int a, input int bmul, input int badd, input bit sub);
        int unsigned b, p;
        check("in_ready_beat", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_a     = LOGQ'(a);
        in_sub   = sub;
        for (int l = 0; l < LANES; l++) begin
            b = (bmul * (l + 1) + badd) % Q;
            in_b[l*LOGQ +: LOGQ] = LOGQ'(b);
            p = (a * b) % Q;
            mdl_acc[l] = sub ? (mdl_acc[l] + Q - p) % Q : (mdl_acc[l] + p) % Q;
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Called one half-cycle after the edge that took the last beat.
    task automatic finish_job();
        check("in_ready_drop", 64'(in_ready), 64'd0);
        check("lat_e1_no_valid", 64'(out_valid), 64'd0);
        tick();
        check("lat_e2_no_valid", 64'(out_valid), 64'd0);
        tick();
        check("lat_e3_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic release_job();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_after_release", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; cfg_len = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
        for (int l = 0; l < LANES; l++) mdl_acc[l] = 0;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_acc", 64'(out_acc), 64'd0);
        rst = 1'b1;
        tick();

        // Basic accumulate.
        start_job(3);
        beat(2, 1, 0, 0);
        beat(3, 1, 0, 0);
        beat(4, 1, 0, 0);
        finish_job();
        check("basic_lit", 64'(out_acc), 64'(lanes_lin(9)));
        release_job();

        // Wrap and subtract.
        start_job(2);
        beat(8191, 0, 8191, 0);
        beat(1, 0, 5, 1);
        finish_job();
        check("wrap_sub_lit", 64'(out_acc), 64'(lanes_all(8188)));
        release_job();

        // Bubbles and output back-pressure.
        start_job(4);
        beat(1, 1, 0, 0); tick();
        beat(2, 1, 0, 0); tick();
        beat(3, 1, 0, 0); tick();
        beat(4, 1, 0, 0);
        finish_job();
        held = out_acc;
        repeat (5) begin
            tick();
            check("bp_valid_held", 64'(out_valid), 64'd1);
            check("bp_acc_stable", 64'(out_acc), 64'(held));
        end
        check("bubble_lit", 64'(out_acc), 64'(lanes_lin(10)));
        release_job();

        // Zero-length job.
        start_job(0);
        check("zero_done", 64'(out_valid), 64'd1);
        check("zero_acc", 64'(out_acc), 64'd0);
        release_job();

        // Length clamp: surplus valid beats after MAX_LEN are not taken.
        start_job(MAX_LEN + 5);
        for (int i = 0; i < MAX_LEN; i++) beat(1, 1, 0, 0);
        in_valid = 1'b1;
        in_a     = LOGQ'(100);
        finish_job();
        in_valid = 1'b0;
        check("clamp_lit", 64'(out_acc), 64'(lanes_lin(MAX_LEN)));
        release_job();

        // Reset in the middle of a job.
        start_job(5);
        beat(3, 1, 0, 0);
        beat(3, 1, 0, 0);
        rst = 1'b0;
        tick();
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_ready", 64'(in_ready), 64'd0);
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_acc", 64'(out_acc), 64'd0);
        rst = 1'b1;
        tick();
        start_job(1);
        beat(7, 0, 7, 0);
        finish_job();
        check("after_rst_lit", 64'(out_acc), 64'(lanes_all(49)));
        release_job();

        // Ignored inputs in IDLE.
        in_valid  = 1'b1;
        in_a      = LOGQ'(5);
        in_b      = lanes_all(5);
        out_ready = 1'b1;
        repeat (2) tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("idle_inval_busy", 64'(busy), 64'd0);
        check("idle_inval_acc", 64'(out_acc), 64'(lanes_all(49)));

        // start and out_ready during ACCUM are ignored; len is not re-latched.
        start_job(2);
        start     = 1'b1;
        cfg_len   = CW'(1);
        out_ready = 1'b1;
        beat(2, 1, 0, 0);
        start     = 1'b0;
        out_ready = 1'b0;
        beat(3, 1, 0, 0);
        finish_job();
        check("ignored_lit", 64'(out_acc), 64'(lanes_lin(5)));

        // start in the cycle DONE completes is ignored.
        start     = 1'b1;
        cfg_len   = CW'(3);
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        check("start_at_done_exit", 64'(busy), 64'd0);
        tick();
        check("still_idle", 64'(busy), 64'd0);
        check("acc_kept_idle", 64'(out_acc), 64'(lanes_lin(5)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
